// File: rtl/sfp_seq.sv
// Sequencer between psum SRAM and the sfp accumulate/ReLU unit: per output pixel it
// clears sfp, streams num_kij partial sums into it, applies ReLU and hands the result off.
module sfp_seq #(
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int num_kij = 9,
  parameter int num_o   = 16,
  localparam int O_W    = (num_o > 1) ? $clog2(num_o) : 1,
  localparam int K_W    = (num_kij > 1) ? $clog2(num_kij + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] base_addr,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [addr_bw-1:0] rd_addr,
  input  logic [psum_bw-1:0] rd_data,
  output logic               sfp_clr,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic [psum_bw-1:0] sfp_data,
  input  logic [psum_bw-1:0] sfp_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_data,
  output logic [O_W-1:0]     out_addr,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_RELU  = 3'd4,
    S_WR    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [K_W-1:0]     K_LAST    = K_W'(num_kij - 1);
  localparam logic [O_W-1:0]     O_LAST    = O_W'(num_o - 1);
  localparam logic [addr_bw-1:0] ADDR_STEP = addr_bw'(num_o);

  state_t             r_state;
  logic [addr_bw-1:0] r_base;
  logic [addr_bw-1:0] r_rd_addr;
  logic [O_W-1:0]     r_o;
  logic [K_W-1:0]     r_k;
  logic               r_busy;
  logic               r_done;
  logic               r_rd_en;
  logic               r_sfp_clr;
  logic               r_sfp_acc;
  logic               r_sfp_relu;
  logic               r_out_valid;
  logic               w_handshake;

  // Result port: out_valid rises on WR entry and, together with out_data/out_addr,
  // holds until a cycle with out_valid & out_ready; that cycle is the only transfer.
  assign w_handshake = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_rd_addr   <= '0;
      r_o         <= '0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_sfp_clr   <= 1'b0;
      r_sfp_acc   <= 1'b0;
      r_sfp_relu  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // SRAM data lands one cycle after the read, so acc trails rd_en by one cycle.
      r_sfp_acc <= r_rd_en;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base    <= base_addr;
            r_o       <= '0;
            r_busy    <= 1'b1;
            r_sfp_clr <= 1'b1;
            r_state   <= S_CLR;
          end
        end
        S_CLR: begin
          r_k       <= '0;
          r_rd_addr <= r_base + addr_bw'(r_o);
          r_sfp_clr <= 1'b0;
          r_rd_en   <= 1'b1;
          r_state   <= S_RD;
        end
        S_RD: begin
          r_k       <= r_k + 1'b1;
          r_rd_addr <= r_rd_addr + ADDR_STEP;
          if (r_k == K_LAST) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_sfp_relu <= 1'b1;
          r_state    <= S_RELU;
        end
        S_RELU: begin
          r_sfp_relu  <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_WR;
        end
        S_WR: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (r_o == O_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_o       <= r_o + 1'b1;
              r_sfp_clr <= 1'b1;
              r_state   <= S_CLR;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign sfp_clr   = r_sfp_clr;
  assign sfp_acc   = r_sfp_acc;
  assign sfp_relu  = r_sfp_relu;
  // Gated pass-throughs keep every output at zero while reset holds the registers.
  assign sfp_data  = r_sfp_acc ? rd_data : '0;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? sfp_result : '0;
  assign out_addr  = r_o;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sfp_seq.sv
// Directed bench for sfp_seq: SRAM and sfp behavioural models, expected-result queue,
// per-cycle protocol checks and one summary line.
module tb_sfp_seq;

  localparam int PSUM_BW = 16;
  localparam int ADDR_BW = 11;
  localparam int NUM_KIJ = 9;
  localparam int NUM_O   = 16;
  localparam int MEM_SZ  = 2048;

  logic               clk;
  logic               reset;
  logic               start;
  logic [ADDR_BW-1:0] base_addr;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [ADDR_BW-1:0] rd_addr;
  logic [PSUM_BW-1:0] rd_data;
  logic               sfp_clr;
  logic               sfp_acc;
  logic               sfp_relu;
  logic [PSUM_BW-1:0] sfp_data;
  logic [PSUM_BW-1:0] sfp_result;
  logic               out_valid;
  logic               out_ready;
  logic [PSUM_BW-1:0] out_data;
  logic [3:0]         out_addr;
  logic [2:0]         dbg_state;

  logic [PSUM_BW-1:0] mem [0:MEM_SZ-1];
  logic [PSUM_BW-1:0] acc_reg;
  logic [19:0]        exp_q[$];
  logic [ADDR_BW-1:0] rd_log[$];
  int                 n_cmp;
  int                 n_err;

  sfp_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .sfp_clr    (sfp_clr),
    .sfp_acc    (sfp_acc),
    .sfp_relu   (sfp_relu),
    .sfp_data   (sfp_data),
    .sfp_result (sfp_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // psum SRAM: registered read
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // sfp: synchronous clear, accumulate, in-place ReLU
  always @(posedge clk) begin
    if (sfp_clr)       acc_reg <= '0;
    else if (sfp_acc)  acc_reg <= acc_reg + sfp_data;
    else if (sfp_relu) acc_reg <= acc_reg[PSUM_BW-1] ? '0 : acc_reg;
  end
  assign sfp_result = acc_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [PSUM_BW-1:0] model(input int base, input int o);
    logic [PSUM_BW-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_KIJ; k++) s = s + mem[(base + k * NUM_O + o) % MEM_SZ];
    return s[PSUM_BW-1] ? '0 : s;
  endfunction

  task automatic fill_ramp();
    for (int a = 0; a < MEM_SZ; a++) mem[a] = '0;
    for (int k = 0; k < NUM_KIJ; k++)
      for (int o = 0; o < NUM_O; o++) mem[k * NUM_O + o] = 16'(k + o);
  endtask

  task automatic push_ramp();
    exp_q.delete();
    for (int o = 0; o < NUM_O; o++) exp_q.push_back({4'(o), 16'(36 + 9 * o)});
  endtask

  // Drives one run and checks every cycle; inputs change 1 time unit after negedge.
  task automatic run(input int base, input bit inject, input bit stall, input int abort_px,
                     output int n, output bit aborted);
    int stall_cnt, acc_cnt, rd_seen, done_cnt;
    bit got_done;
    logic [19:0] e;
    stall_cnt = 0; acc_cnt = 0; rd_seen = 0; done_cnt = 0; got_done = 0;
    n = 0; aborted = 0;
    rd_log.delete();
    @(negedge clk); #1;
    base_addr = ADDR_BW'(base);
    start     = 1'b1;
    out_ready = !stall;
    while (n < 2000 && !got_done) begin
      @(negedge clk); #1;
      n++;
      start = inject && (n == 20);
      if (inject && n == 20) base_addr = ADDR_BW'(base + 500);
      check("excl", 32'(int'(sfp_clr) + int'(sfp_acc) + int'(sfp_relu) > 1), 32'd0);
      if (rd_en && out_addr == 4'd0 && rd_log.size() < 3) rd_log.push_back(rd_addr);
      if (sfp_acc) acc_cnt++;
      if (sfp_relu) begin
        check("acc_len", 32'(acc_cnt), 32'(NUM_KIJ));
        acc_cnt = 0;
      end
      if (stall && out_valid && out_addr == 4'd0 && stall_cnt < 6) begin
        stall_cnt++;
        check("stall_data", 32'(out_data), 32'(exp_q[0][15:0]));
        check("stall_addr", 32'(out_addr), 32'd0);
        check("stall_rd_en", 32'(rd_en), 32'd0);
        if (stall_cnt == 6) out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_result", 32'(out_addr), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("result", 32'({out_addr, out_data}), 32'(e));
        end
      end
      if (abort_px >= 0 && rd_en && out_addr == 4'(abort_px)) begin
        rd_seen++;
        if (rd_seen == 3) begin
          aborted = 1;
          return;
        end
      end
      if (done) begin
        got_done = 1;
        done_cnt = 1;
        check("busy_in_done", 32'(busy), 32'd1);
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (done) done_cnt++;
    end
    check("done_count", 32'(done_cnt), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("left_in_q", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int  n;
    bit  ab;
    n_cmp = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; base_addr = '0; out_ready = 1'b1;
    fill_ramp();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", 32'({busy, done, rd_en, sfp_clr, sfp_acc, sfp_relu, out_valid}), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out", 32'({out_addr, out_data, sfp_data}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_after_rst", 32'({busy, done, rd_en, out_valid}), 32'd0);

    // Ramp data: out = 36 + 9*o, 209 cycles start to done
    push_ramp();
    run(0, 0, 0, -1, n, ab);
    check("run_len", 32'(n), 32'd209);

    // Second start and base change mid-run are ignored
    push_ramp();
    run(0, 1, 0, -1, n, ab);
    check("inject_run_len", 32'(n), 32'd209);

    // Back-pressure on pixel 0
    push_ramp();
    run(0, 0, 1, -1, n, ab);
    check("stall_run_len", 32'(n), 32'd214);

    // Reset mid-RD of pixel 7, then a clean rerun
    push_ramp();
    run(0, 0, 0, 7, n, ab);
    check("abort_reached", 32'(ab), 32'd1);
    reset = 1'b0;
    #1;
    check("async_ctl", 32'({busy, done, rd_en, sfp_clr, sfp_acc, sfp_relu, out_valid}), 32'd0);
    check("async_rd_addr", 32'(rd_addr), 32'd0);
    check("async_out", 32'({out_addr, out_data, sfp_data}), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_idle", 32'({busy, out_valid, rd_en}), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    push_ramp();
    run(0, 0, 0, -1, n, ab);
    check("rerun_len", 32'(n), 32'd209);

    // Pixel 3 negative -> ReLU zero, others 9
    for (int a = 0; a < MEM_SZ; a++) mem[a] = '0;
    for (int k = 0; k < NUM_KIJ; k++)
      for (int o = 0; o < NUM_O; o++) mem[100 + k * NUM_O + o] = (o == 3) ? -16'sd5 : 16'd1;
    exp_q.delete();
    for (int o = 0; o < NUM_O; o++) exp_q.push_back({4'(o), (o == 3) ? 16'd0 : 16'd9});
    run(100, 0, 0, -1, n, ab);

    // Base near top of address space wraps modulo 2048
    for (int a = 0; a < MEM_SZ; a++) mem[a] = 16'((a * 37) % 23) - 16'd11;
    exp_q.delete();
    for (int o = 0; o < NUM_O; o++) exp_q.push_back({4'(o), model(2040, o)});
    run(2040, 0, 0, -1, n, ab);
    check("wrap_rd0", 32'(rd_log.size() > 0 ? rd_log[0] : 11'h7FF), 32'd2040);
    check("wrap_rd1", 32'(rd_log.size() > 1 ? rd_log[1] : 11'h7FF), 32'd8);
    check("wrap_rd2", 32'(rd_log.size() > 2 ? rd_log[2] : 11'h7FF), 32'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
